hazard_scoreboard: RTL

//  Parametrised forwarding/hazard controller replacing the fixed 2-stage forwarding unit and load-use

---
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - parametrised load-use stall / EX forwarding scoreboard
// Optional FWD_WB_BYPASS_EN adds a retired-instruction entry for regfiles without write-through.
module hazard_scoreboard #(
  parameter int RBITS     = 5,
  parameter int NSRC      = 2,
  parameter int DEPTH     = 3,
  parameter int LOAD_RDY  = 2,
  parameter int ALU_RDY   = 1,
  parameter int FLUSH_DEP = 2,
  parameter int ZERO_REG  = 31,
  parameter int CNT_W     = 16,
`ifdef FWD_WB_BYPASS_EN
  localparam int NE       = DEPTH + 1,
`else
  localparam int NE       = DEPTH,
`endif
  localparam int SELW     = $clog2(NE + 1)
) (
  input  logic                  CLK,
  input  logic                  resetl,
  input  logic                  id_valid,
  input  logic [NSRC*RBITS-1:0] id_src,
  input  logic [RBITS-1:0]      id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [NSRC*SELW-1:0]  ex_fwd_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [RBITS-1:0] ZR = RBITS'(ZERO_REG);

  logic [NE-1:0]         v;
  logic [NE-1:0]         rw;
  logic [NE-1:0]         mr;
  logic [RBITS-1:0]      rd [NE];
  logic [NSRC*RBITS-1:0] ex_src;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      v         <= '0;
      rw        <= '0;
      mr        <= '0;
      for (int k = 0; k < NE; k++) rd[k] <= '0;
      ex_src    <= '0;
      stall_cnt <= '0;
    end else begin
      v[0]  <= id_valid & ~stall & ~flush;
      rd[0] <= id_rd;
      rw[0] <= id_regwrite;
      mr[0] <= id_memread;
      // A flush kills the younger in-flight entries as they shift down.
      for (int k = 1; k < NE; k++) begin
        v[k]  <= (flush && (k < FLUSH_DEP)) ? 1'b0 : v[k-1];
        rd[k] <= rd[k-1];
        rw[k] <= rw[k-1];
        mr[k] <= mr[k-1];
      end
      if (!stall) ex_src <= id_src;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Only the youngest producer of a source decides whether ID must wait.
  always_comb begin
    logic [RBITS-1:0] src;
    logic             found;
    logic             need;
    src   = '0;
    found = 1'b0;
    need  = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      src   = id_src[s*RBITS +: RBITS];
      found = 1'b0;
      for (int k = 0; k < NE; k++) begin
        if (!found && v[k] && rw[k] && (rd[k] == src) && (src != ZR)) begin
          found = 1'b1;
          if ((k + 1) < (mr[k] ? LOAD_RDY : ALU_RDY)) need = 1'b1;
        end
      end
    end
    stall = id_valid & ~flush & need;
  end

  assign ex_valid = v[0];

  always_comb begin
    logic [RBITS-1:0] src;
    logic [SELW-1:0]  sel;
    src        = '0;
    sel        = '0;
    ex_fwd_sel = '0;
    for (int s = 0; s < NSRC; s++) begin
      src = ex_src[s*RBITS +: RBITS];
      sel = '0;
      for (int k = NE - 1; k >= 1; k--) begin
        if (v[k] && rw[k] && (rd[k] == src) && (src != ZR)) sel = SELW'(k);
      end
      ex_fwd_sel[s*SELW +: SELW] = ex_valid ? sel : '0;
    end
  end

endmodule
